uart_fifo_tx: RTL and testbench

Serial transmitter that drains the byte FIFO and drives the board UART TX pin. It sits on the read side of the FIFO. It watches `fifo_empty`, captures the FIFO head word, pops the word with a single-cycle `fifo_read_en` pulse, and serialises the word as 8N1 (or 8N2) at a fixed baud rate derived from the system clock.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo_tx_if.sv | 21 ++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_fifo_tx.sv | 131 +++++++++++++
 tb/tb_uart_fifo_tx.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state codes, line level and baud helper.
// Used by the transmitter today and the receiver later.
package uart_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    localparam logic LINE_IDLE = 1'b1;

    // Clock cycles per serial bit, truncated.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_fifo_tx_if.sv
// FIFO read-side bundle between the byte FIFO and the transmitter.
// master = transmitter (pops), slave = FIFO (supplies head word).
interface uart_fifo_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_read_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_read_en
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running bit-period counter with synchronous clear.
// tick is high for one cycle at terminal count.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = !clear && (cnt_q == TERM);

    // Next count: hold at zero while cleared, wrap at terminal count.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// FIFO-fed UART transmitter: pops one word per frame and sends it
// LSB first as 8N1/8N2 with registered tx, busy and pop outputs.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD       = 115200,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    uart_fifo_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BW  = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  tx_q, tx_d;
    logic                  rd_q, rd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tick;
    logic                  baud_clear;

    // Baud counter sits at zero in IDLE so a frame starts aligned.
    assign baud_clear = (state_q == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CPB)
    ) u_baud (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (baud_clear),
        .tick   (tick)
    );

    // Frame sequencing and next values of all registered outputs.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && !fifo.fifo_empty) begin
                    state_d = ST_START;
                    shift_d = fifo.fifo_data;
                    bit_d   = '0;
                    rd_d    = 1'b1;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == LAST_DATA) begin
                        state_d = ST_STOP;
                        tx_d    = LINE_IDLE;
                        bit_d   = '0;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        tx_d    = LINE_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces the line idle at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= LINE_IDLE;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo.fifo_read_en = rd_q;
    assign tx                = tx_q;
    assign busy              = busy_q;
    assign frame_done        = done_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: FIFO model, waveform reference and decoder.
// Two instances cover one and two stop bits.
module tb_uart_fifo_tx;

    localparam int CPB = 4;

    logic clock = 1'b0;
    logic reset_n;
    logic en0, en1;
    logic tx0, busy0, done0;
    logic tx1, busy1, done1;

    int total = 0;
    int bad   = 0;

    uart_fifo_tx_if #(.DATA_WIDTH(8)) if0 ();
    uart_fifo_tx_if #(.DATA_WIDTH(8)) if1 ();

    uart_fifo_tx #(
        .DATA_WIDTH(8),
        .CLK_FREQ  (1_000_000),
        .BAUD      (250_000),
        .STOP_BITS (1)
    ) u_dut0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (en0),
        .fifo      (if0),
        .tx        (tx0),
        .busy      (busy0),
        .frame_done(done0)
    );

    uart_fifo_tx #(
        .DATA_WIDTH(8),
        .CLK_FREQ  (1_000_000),
        .BAUD      (250_000),
        .STOP_BITS (2)
    ) u_dut1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (en1),
        .fifo      (if1),
        .tx        (tx1),
        .busy      (busy1),
        .frame_done(done1)
    );

    always #5 clock = ~clock;

    // FIFO models: array plus pointers, pop on rising edge of read_en.
    logic [7:0] mem0 [64];
    logic [7:0] mem1 [64];
    int wp0 = 0;
    int wp1 = 0;
    int rp0 = 0;
    int rp1 = 0;
    logic rdp0 = 1'b0;
    logic rdp1 = 1'b0;

    always @(negedge clock) begin
        if (if0.fifo_read_en && !rdp0 && rp0 != wp0) rp0++;
        if (if1.fifo_read_en && !rdp1 && rp1 != wp1) rp1++;
        rdp0 = if0.fifo_read_en;
        rdp1 = if1.fifo_read_en;
        if0.fifo_empty = (rp0 == wp0);
        if1.fifo_empty = (rp1 == wp1);
        if0.fifo_data  = mem0[rp0 % 64];
        if1.fifo_data  = mem1[rp1 % 64];
    end

    task automatic push(input int sel, input logic [7:0] b);
        if (sel == 0) begin
            mem0[wp0 % 64] = b;
            wp0++;
        end else begin
            mem1[wp1 % 64] = b;
            wp1++;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic s_tx(input int sel);
        return (sel != 0) ? tx1 : tx0;
    endfunction

    function automatic logic s_busy(input int sel);
        return (sel != 0) ? busy1 : busy0;
    endfunction

    function automatic logic s_done(input int sel);
        return (sel != 0) ? done1 : done0;
    endfunction

    function automatic logic s_rd(input int sel);
        return (sel != 0) ? if1.fifo_read_en : if0.fifo_read_en;
    endfunction

    // Wait for a pop, then compare the whole frame with the ideal line.
    task automatic frame_check(input int sel, input logic [7:0] b,
                               input int nstop, output int waited);
        int fl;
        int rd_hits;
        logic busy_all;
        logic e;
        logic [63:0] obs;
        logic [63:0] expv;
        logic [7:0] dec;
        fl = (1 + 8 + nstop) * CPB;
        waited = 0;
        while (!s_rd(sel) && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        if (!s_rd(sel)) begin
            check("start_timeout", 64'(0), 64'(1));
            return;
        end
        obs = '0;
        expv = '0;
        rd_hits = 0;
        busy_all = 1'b1;
        for (int k = 0; k < fl; k++) begin
            if (k < CPB) e = 1'b0;
            else if (k < 9 * CPB) e = b[k / CPB - 1];
            else e = 1'b1;
            obs[k] = s_tx(sel);
            expv[k] = e;
            if (s_rd(sel)) rd_hits++;
            busy_all &= s_busy(sel);
            @(negedge clock);
        end
        check("frame_done", 64'(s_done(sel)), 64'(1));
        check("busy_after", 64'(s_busy(sel)), 64'(0));
        check("tx_wave", obs, expv);
        check("busy_during", 64'(busy_all), 64'(1));
        check("rd_pulses", 64'(rd_hits), 64'(1));
        for (int i = 0; i < 8; i++) dec[i] = obs[(i + 1) * CPB + CPB / 2];
        check("decode", 64'(dec), 64'(b));
        @(negedge clock);
        check("done_width", 64'(s_done(sel)), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic any_low, any_busy, any_rd, any_done;
        logic [7:0] rb;
        reset_n = 1'b0;
        en0 = 1'b1;
        en1 = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_tx", 64'(tx0), 64'(1));
        check("rst_busy", 64'(busy0), 64'(0));
        check("rst_rd", 64'(if0.fifo_read_en), 64'(0));
        check("rst_done", 64'(done0), 64'(0));
        check("rst_tx_sb2", 64'(tx1), 64'(1));
        reset_n = 1'b1;

        any_low = 0; any_busy = 0; any_rd = 0;
        repeat (100) begin
            @(negedge clock);
            any_low  |= !tx0 || !tx1;
            any_busy |= busy0 || busy1;
            any_rd   |= if0.fifo_read_en || if1.fifo_read_en;
        end
        check("idle_tx_low", 64'(any_low), 64'(0));
        check("idle_busy", 64'(any_busy), 64'(0));
        check("idle_rd", 64'(any_rd), 64'(0));

        @(posedge clock); #2;
        push(0, 8'hA5);
        frame_check(0, 8'hA5, 1, w);
        check("a5_latency", 64'(w), 64'(2));

        @(posedge clock); #2;
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        frame_check(0, 8'h00, 1, w);
        check("b2b_lat0", 64'(w), 64'(2));
        frame_check(0, 8'hFF, 1, w);
        check("b2b_gap1", 64'(w), 64'(0));
        frame_check(0, 8'h3C, 1, w);
        check("b2b_gap2", 64'(w), 64'(0));
        check("b2b_pops", 64'(rp0), 64'(4));

        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom);
            repeat ($urandom_range(0, 4)) @(posedge clock);
            @(posedge clock); #2;
            push(0, rb);
            frame_check(0, rb, 1, w);
            check("rnd_latency", 64'(w), 64'(2));
        end
        check("rnd_pops", 64'(rp0), 64'(12));

        @(posedge clock); #2;
        push(0, 8'h55);
        push(0, 8'h66);
        fork
            frame_check(0, 8'h55, 1, w);
            begin
                repeat (20) @(negedge clock);
                en0 = 1'b0;
            end
        join
        any_low = 0; any_busy = 0; any_rd = 0;
        repeat (30) begin
            @(negedge clock);
            any_low  |= !tx0;
            any_busy |= busy0;
            any_rd   |= if0.fifo_read_en;
        end
        check("gate_tx", 64'(any_low), 64'(0));
        check("gate_busy", 64'(any_busy), 64'(0));
        check("gate_rd", 64'(any_rd), 64'(0));
        check("gate_pops", 64'(rp0), 64'(13));
        check("gate_pending", 64'(if0.fifo_empty), 64'(0));
        en0 = 1'b1;
        frame_check(0, 8'h66, 1, w);
        check("gate_resume", 64'(w), 64'(1));

        @(posedge clock); #2;
        push(0, 8'h96);
        push(0, 8'h5A);
        w = 0;
        while (!if0.fifo_read_en && w < 10) begin
            @(negedge clock);
            w++;
        end
        check("mid_start", 64'(if0.fifo_read_en), 64'(1));
        repeat (16) @(negedge clock);
        check("mid_tx_bit3", 64'(tx0), 64'(0));
        #2 reset_n = 1'b0;
        #1;
        check("mid_async_tx", 64'(tx0), 64'(1));
        check("mid_async_busy", 64'(busy0), 64'(0));
        any_done = 0;
        repeat (3) begin
            @(negedge clock);
            any_done |= done0;
        end
        reset_n = 1'b1;
        check("mid_no_done", 64'(any_done), 64'(0));
        frame_check(0, 8'h5A, 1, w);
        check("post_rst_lat", 64'(w), 64'(1));
        check("mid_pops", 64'(rp0), 64'(16));

        @(posedge clock); #2;
        push(1, 8'h81);
        frame_check(1, 8'h81, 2, w);
        check("sb2_latency", 64'(w), 64'(2));
        check("sb2_pops", 64'(rp1), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
